// File: rtl/lib_cpu.sv
// Shared CPU types: opcodes, fetch FSM states and reset constants.
package lib_cpu;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } OPECODE;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [15:0] STALL_MAX        = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == STALL_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection for the held instruction; jump beats taken branch.
module pc_next
    import lib_cpu::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        jmp,
    input  logic        alu_zero,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;
    logic [31:0] br_target;
    logic [31:0] j_target;

    assign br_off    = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc_plus4 + br_off;
    assign j_target  = {pc_plus4[31:28], instr[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jmp)
            next_pc = j_target;
        else if (branch && alu_zero)
            next_pc = br_target;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request, wait for memory, hold until decode retires.
module fetch_unit
    import lib_cpu::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output OPECODE      op,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        branch,
    input  logic        jmp,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [15:0] stall_cnt
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = {pc[31:2], 2'b00};
    assign op        = OPECODE'(instr[31:26]);
    // Gated by reset so the request drops at once and rises on release.
    assign imem_req  = reset_n & (state == S_REQ);

    pc_next u_pc_next (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .branch   (branch),
        .jmp      (jmp),
        .alu_zero (alu_zero),
        .next_pc  (next_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            stall_cnt   <= 16'd0;
        end else begin
            unique case (state)
                S_REQ: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        stall_cnt <= sat_inc16(stall_cnt);
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
module tb_fetch_unit;
    import lib_cpu::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic        branch = 1'b0;
    logic        jmp = 1'b0;
    logic        alu_zero = 1'b0;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    OPECODE      op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] stall_cnt;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic [31:0] w_instr;
    OPECODE      w_op;
    logic        w_instr_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc_plus4;
    logic [15:0] w_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .branch      (branch),
        .jmp         (jmp),
        .alu_zero    (alu_zero),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .stall_cnt   (stall_cnt)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (w_imem_req),
        .imem_addr   (w_imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (w_instr),
        .op          (w_op),
        .instr_valid (w_instr_valid),
        .instr_ready (instr_ready),
        .branch      (branch),
        .jmp         (jmp),
        .alu_zero    (alu_zero),
        .pc          (w_pc),
        .pc_plus4    (w_pc_plus4),
        .stall_cnt   (w_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in S_REQ; returns in S_HOLD with the word latched.
    task automatic fetch(input logic [31:0] word);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        step();
        imem_rvalid = 1'b0;
    endtask

    task automatic retire(input logic b, input logic j, input logic z);
        instr_ready = 1'b1;
        branch      = b;
        jmp         = j;
        alu_zero    = z;
        step();
        instr_ready = 1'b0;
        branch      = 1'b0;
        jmp         = 1'b0;
        alu_zero    = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_stall", {16'd0, stall_cnt}, 32'd0);

        reset_n = 1'b1;
        #1;
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'd0);

        step();
        check("wait_req", {31'd0, imem_req}, 32'd0);
        check("wait_valid", {31'd0, instr_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2008_0005;
        step();
        imem_rvalid = 1'b0;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, 32'h2008_0005);
        check("hold_op", {26'd0, op}, {26'd0, OP_ADDI});
        check("hold_pc", pc, 32'd0);
        check("hold_pc4", pc_plus4, 32'd4);
        check("wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", w_pc_plus4, 32'd0);

        // Hold with stray rvalid: instruction must not change.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        step();
        imem_rvalid = 1'b0;
        check("hold_stable", instr, 32'h2008_0005);
        check("hold_still", {31'd0, instr_valid}, 32'd1);

        retire(1'b0, 1'b0, 1'b0);
        check("seq_req", {31'd0, imem_req}, 32'd1);
        check("seq_addr", imem_addr, 32'h4);
        check("seq_valid", {31'd0, instr_valid}, 32'd0);
        check("wrap_addr", w_imem_addr, 32'h0);

        fetch(32'h0800_0004);
        check("j_op", {26'd0, op}, {26'd0, OP_J});
        retire(1'b0, 1'b1, 1'b0);
        check("j_addr", imem_addr, 32'h10);

        fetch(32'h1000_FFFF);
        check("beq_op", {26'd0, op}, {26'd0, OP_BEQ});
        retire(1'b1, 1'b0, 1'b1);
        check("br_taken", imem_addr, 32'h10);

        fetch(32'h1000_FFFF);
        retire(1'b1, 1'b0, 1'b0);
        check("br_not", imem_addr, 32'h14);

        // instr_ready in S_REQ must not move the PC.
        instr_ready = 1'b1;
        jmp         = 1'b1;
        step();
        instr_ready = 1'b0;
        jmp         = 1'b0;
        check("rdy_ign_pc", pc, 32'h14);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0800_0040;
        step();
        imem_rvalid = 1'b0;
        check("rdy_ign_hold", {31'd0, instr_valid}, 32'd1);
        retire(1'b1, 1'b1, 1'b1);
        check("j_wins", imem_addr, 32'h100);
        check("stall_zero", {16'd0, stall_cnt}, 32'd0);

        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", {31'd0, instr_valid}, 32'd0);
            check("stall_req", {31'd0, imem_req}, 32'd0);
        end
        check("stall_cnt", {16'd0, stall_cnt}, 32'd5);

        reset_n = 1'b0;
        #2;
        check("ar_pc", pc, 32'd0);
        check("ar_req", {31'd0, imem_req}, 32'd0);
        check("ar_valid", {31'd0, instr_valid}, 32'd0);
        check("ar_instr", instr, 32'd0);
        check("ar_stall", {16'd0, stall_cnt}, 32'd0);
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0001;
        #1;
        check("rr_req", {31'd0, imem_req}, 32'd1);
        check("rr_addr", imem_addr, 32'd0);
        step();
        imem_rvalid = 1'b0;
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        check("late_instr", instr, 32'd0);
        check("late_req", {31'd0, imem_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Port clk, input, 1, SHALL be the sole clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1, SHALL be the reset: asynchronous assertion, active-low.
REQ-004 Port imem_req, output, 1, SHALL request an instruction-memory read.
REQ-005 Port imem_addr, output, 32, SHALL carry the word address (byte address, [1:0]=0) of the request.
REQ-006 Port imem_rvalid, input, 1, SHALL indicate that imem_rdata is valid this cycle.
REQ-007 Port imem_rdata, input, 32, SHALL carry the fetched instruction word.
REQ-008 Port instr, output, 32, SHALL carry the held instruction to the datapath.
REQ-009 Port op, output, OPECODE, SHALL equal instr[31:26] and feed the main decoder.
REQ-010 Port instr_valid, output, 1, SHALL mark instr/op as valid for decode.
REQ-011 Port instr_ready, input, 1, SHALL retire the held instruction when high with instr_valid.
REQ-012 Ports branch and jmp, input, 1 each, SHALL take the decoder's branch and jump controls.
REQ-013 Port alu_zero, input, 1, SHALL take the ALU zero flag for the held instruction.
REQ-014 Ports pc and pc_plus4, output, 32 each, SHALL give the held instruction's address and that address plus 4.
REQ-015 Port stall_cnt, output, 16, SHALL count cycles spent waiting on memory.

Function
REQ-016 The FSM SHALL have states S_REQ, S_WAIT and S_HOLD.
REQ-017 In S_REQ: imem_req=1, imem_addr=pc, and the FSM SHALL move to S_WAIT unconditionally the next cycle.
REQ-018 In S_WAIT: imem_req=0; on imem_rvalid the FSM SHALL latch imem_rdata into instr and move to S_HOLD; otherwise it SHALL stay and increment stall_cnt.
REQ-019 stall_cnt SHALL saturate at 16'hFFFF rather than wrap.
REQ-020 In S_HOLD: instr_valid=1; instr SHALL stay stable until retirement.
REQ-021 When instr_ready=1 in S_HOLD, pc SHALL load next_pc and the FSM SHALL move to S_REQ.
REQ-022 next_pc selection:
- jmp=1: {pc_plus4[31:28], instr[25:0], 2'b00}
- branch&alu_zero=1: pc_plus4 + (sign-extended instr[15:0] << 2)
- otherwise: pc_plus4
- jmp SHALL take priority over branch.
REQ-023 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 SHALL wrap to 0.
REQ-024 imem_rvalid outside S_WAIT SHALL be ignored with no state change.
REQ-025 instr_ready outside S_HOLD SHALL be ignored.
REQ-026 rvalid in the same cycle as entry to S_WAIT is impossible; the earliest accepted rvalid is the first S_WAIT cycle, giving a minimum 3 cycles per instruction (REQ, WAIT, HOLD).

Reset
REQ-027 While reset_n=0, the block SHALL hold: pc=RESET_PC, state=S_REQ, instr=0, instr_valid=0, imem_req=0, stall_cnt=0.
REQ-028 Reset asserted mid-fetch SHALL abandon the outstanding request; a late rvalid after release SHALL be ignored per REQ-024.
REQ-029 The first cycle after reset_n rises SHALL assert imem_req with imem_addr=RESET_PC.

Structure
REQ-030 The fetch_state_t enum and the default RESET_PC constant SHALL live in lib_cpu alongside OPECODE.
REQ-031 Next-PC selection SHALL be one combinational sub-module, pc_next, instantiated inside fetch_unit.

Verification
REQ-032 Reset release, rvalid one cycle after req with rdata=32'h2008_0005 -> imem_addr=0, instr_valid after 2 cycles, op=ADDI, pc=0.
REQ-033 Retire with branch=jmp=0 -> next imem_addr=32'h4.
REQ-034 instr=32'h1000_FFFF, branch=1, alu_zero=1, pc=32'h10 -> next imem_addr=32'h10; with alu_zero=0 -> 32'h14.
REQ-035 instr=32'h0800_0040, jmp=1, branch=1, alu_zero=1 -> next imem_addr=32'h100 (jump wins).
REQ-036 rvalid held low 5 cycles in S_WAIT -> stall_cnt=5, instr_valid=0 throughout, imem_req=0.
REQ-037 reset_n pulsed low in S_WAIT, then rvalid after release -> outputs return to reset values at once, late rvalid ignored, re-request at RESET_PC.
